// File: rtl/mul_seq_arbiter_if.sv
// Bundle between mul_seq_arbiter, its requesters and the shared repeated-addition
// multiplier datapath. master = arbiter side, slave = requesters plus datapath.
interface mul_seq_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [2*W-1:0]    result;
  logic              ld_a;
  logic              ld_b;
  logic              clr;
  logic              ld_p;
  logic              dec;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic              eqz;
  logic [2*W-1:0]    prod_in;

  modport master (
    input  req, a_in, b_in, eqz, prod_in,
    output gnt, done, busy, result, ld_a, ld_b, clr, ld_p, dec, op_a, op_b
  );

  modport slave (
    output req, a_in, b_in, eqz, prod_in,
    input  gnt, done, busy, result, ld_a, ld_b, clr, ld_p, dec, op_a, op_b
  );
endinterface

// File: rtl/mul_seq_arbiter.sv
// Round-robin arbiter + sequencer for a shared repeated-addition multiplier.
// Optional MULSEQ_ZERO_SKIP_EN: zero operands short-circuit through a ZERO state.
module mul_seq_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  mul_seq_arbiter_if.master  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    ADD  = 3'd3,
`ifdef MULSEQ_ZERO_SKIP_EN
    ZERO = 3'd5,
`endif
    DONE = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [NREQ-1:0]   gnt_q;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [W-1:0]      op_a_q;
  logic [W-1:0]      op_b_q;
  logic [2*W-1:0]    result_q;

  logic [IW-1:0]     sel_c;
  logic [IW-1:0]     lane_c;
  logic              any_req_c;
  logic [W-1:0]      sel_a_c;
  logic [W-1:0]      sel_b_c;
  logic              legal_c;
  logic              ld_a_c;
  logic              ld_b_c;
  logic              clr_c;
  logic              ld_p_c;
  logic              dec_c;

  // Round-robin search: first asserted lane at or above rr_ptr, wrapping.
  always_comb begin
    sel_c     = '0;
    lane_c    = '0;
    any_req_c = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      lane_c = IW'((int'(rr_ptr_q) + k) % NREQ);
      if (!any_req_c && bus.req[lane_c]) begin
        any_req_c = 1'b1;
        sel_c     = lane_c;
      end
    end
  end

  assign sel_a_c = bus.a_in[sel_c*W +: W];
  assign sel_b_c = bus.b_in[sel_c*W +: W];

`ifdef MULSEQ_ZERO_SKIP_EN
  logic zero_op_c;
  assign zero_op_c = (sel_a_c == '0) || (sel_b_c == '0);
`endif

  always_comb begin
    state_nxt = state_q;
    legal_c   = 1'b1;
    ld_a_c    = 1'b0;
    ld_b_c    = 1'b0;
    clr_c     = 1'b0;
    ld_p_c    = 1'b0;
    dec_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req_c) begin
`ifdef MULSEQ_ZERO_SKIP_EN
          state_nxt = zero_op_c ? ZERO : LDA;
`else
          state_nxt = LDA;
`endif
        end
      end
      LDA: begin
        ld_a_c    = 1'b1;
        state_nxt = LDB;
      end
      LDB: begin
        ld_b_c    = 1'b1;
        clr_c     = 1'b1;
        state_nxt = ADD;
      end
      // The zero-check cycle issues no strobes, so ADD lasts b+1 cycles.
      ADD: begin
        if (bus.eqz) begin
          state_nxt = DONE;
        end else begin
          ld_p_c = 1'b1;
          dec_c  = 1'b1;
        end
      end
`ifdef MULSEQ_ZERO_SKIP_EN
      ZERO: begin
        clr_c     = 1'b1;
        state_nxt = DONE;
      end
`endif
      DONE: state_nxt = IDLE;
      default: begin
        legal_c   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Grant capture in IDLE, completion bookkeeping in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q    <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
    end else begin
      if (state_q == IDLE && any_req_c) begin
        gnt_q  <= ONE_HOT0 << sel_c;
        idx_q  <= sel_c;
        op_a_q <= sel_a_c;
        op_b_q <= sel_b_c;
      end
      if (state_q == DONE) begin
        result_q <= bus.prod_in;
        rr_ptr_q <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        gnt_q    <= '0;
      end
      if (!legal_c) begin
        gnt_q <= '0;
      end
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = (state_q == DONE) ? gnt_q : '0;
  assign bus.busy   = (state_q != IDLE);
  assign bus.result = result_q;
  assign bus.op_a   = op_a_q;
  assign bus.op_b   = op_b_q;
  assign bus.ld_a   = ld_a_c;
  assign bus.ld_b   = ld_b_c;
  assign bus.clr    = clr_c;
  assign bus.ld_p   = ld_p_c;
  assign bus.dec    = dec_c;

endmodule

// File: tb/tb_mul_seq_arbiter.sv
// Bench for mul_seq_arbiter: behavioural datapath, table-driven single ops,
// scoreboard of expected products, plus round-robin and reset corner sequences.
`timescale 1ns/1ps
module tb_mul_seq_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
`ifdef MULSEQ_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mul_seq_arbiter_if #(.NREQ(NREQ), .W(W)) bus();
  mul_seq_arbiter #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural multiplier datapath driven by the arbiter strobes
  logic [W-1:0]   a_r = '0;
  logic [W-1:0]   b_r = '0;
  logic [2*W-1:0] p_r = '0;
  always_ff @(posedge clk) begin
    if (bus.ld_a) a_r <= bus.op_a;
    if (bus.ld_b) b_r <= bus.op_b;
    else if (bus.dec) b_r <= b_r - 1'b1;
    if (bus.clr) p_r <= '0;
    else if (bus.ld_p) p_r <= p_r + {{W{1'b0}}, a_r};
  end
  assign bus.eqz     = (b_r == '0);
  assign bus.prod_in = p_r;

  typedef struct {
    int             lane;
    logic [2*W-1:0] res;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int lane;
    int a;
    int b;
    int res;
    int cyc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, want);
    end
  endtask

  // Scoreboard: pop on every done pulse, compare result one cycle later
  logic           res_pend = 1'b0;
  logic [2*W-1:0] res_want = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_pend) begin
        check("result", 32'(bus.result), 32'(res_want));
        res_pend = 1'b0;
      end
      if (rst && bus.done != '0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check("done_lane", 32'(bus.done), 32'(1) << e.lane);
          res_want = e.res;
          res_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input int lane, input int a, input int b, input int want_res,
                        input int want_cyc, input int want_ldp, input int want_lda,
                        input int drop_at);
    int n, cyc, ldp, lda;
    @(negedge clk);
    bus.a_in[lane*W +: W] = W'(a);
    bus.b_in[lane*W +: W] = W'(b);
    bus.req[lane]         = 1'b1;
    sb_q.push_back('{lane, (2*W)'(want_res)});
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt == '0 && n < 40);
    check("grant_onehot", 32'(bus.gnt), 32'(1) << lane);
    check("grant_latency", n, 1);
    cyc = 0; ldp = 0; lda = 0;
    while (bus.done == '0 && cyc < 600) begin
      if (bus.ld_p) ldp++;
      if (bus.ld_a) lda++;
      if (cyc == drop_at) begin
        bus.req[lane]         = 1'b0;
        bus.a_in[lane*W +: W] = 8'hA5;
        bus.b_in[lane*W +: W] = 8'h3C;
      end
      @(negedge clk);
      cyc++;
    end
    check("done_cycle", cyc, want_cyc);
    check("ld_p_cycles", ldp, want_ldp);
    check("ld_a_cycles", lda, want_lda);
    bus.req[lane] = 1'b0;
    @(negedge clk);
    check("idle_after_done", 32'({bus.busy, bus.gnt}), 32'(0));
  endtask

  task automatic arb_seq(input logic [NREQ-1:0] mask, input int n, input int order[5],
                         input int av[NREQ], input int bv[NREQ]);
    int w, c;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      bus.a_in[i*W +: W] = W'(av[i]);
      bus.b_in[i*W +: W] = W'(bv[i]);
    end
    for (int s = 0; s < n; s++)
      sb_q.push_back('{order[s], (2*W)'(av[order[s]] * bv[order[s]])});
    bus.req = mask;
    for (int s = 0; s < n; s++) begin
      w = 0;
      do begin @(negedge clk); w++; end while (bus.gnt == '0 && w < 40);
      check("rr_grant", 32'(bus.gnt), 32'(1) << order[s]);
      c = 0;
      while (bus.done == '0 && c < 600) begin @(negedge clk); c++; end
      check("rr_done_cycle", c, bv[order[s]] + 3);
      if (s == n - 1) bus.req = '0;
      @(negedge clk);
      check("rr_idle_gap", 32'({bus.busy, bus.gnt}), 32'(0));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    vec_t vecs[6];
    int   order[5];
    int   av[NREQ];
    int   bv[NREQ];
    int   zero, n, dones;
    vecs[0] = '{1, 5,   3,   15,    6};
    vecs[1] = '{0, 255, 255, 65025, 258};
    vecs[2] = '{3, 9,   0,   0,     3};
    vecs[3] = '{2, 0,   9,   0,     12};
    vecs[4] = '{0, 1,   1,   1,     4};
    vecs[5] = '{3, 13,  17,  221,   20};

    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bus.gnt, bus.done, bus.busy, bus.ld_a, bus.ld_b,
                               bus.clr, bus.ld_p, bus.dec}), 32'(0));
    check("reset_operands", {bus.op_a, bus.op_b, bus.result}, 32'(0));
    rst = 1'b1;
    @(negedge clk);
    check("idle_no_req", 32'({bus.busy, bus.gnt}), 32'(0));

    foreach (vecs[i]) begin
      zero = (ZS && (vecs[i].a == 0 || vecs[i].b == 0)) ? 1 : 0;
      run_op(vecs[i].lane, vecs[i].a, vecs[i].b, vecs[i].res,
             zero ? 1 : vecs[i].cyc, zero ? 0 : vecs[i].b, zero ? 0 : 1, -1);
    end

    // Request dropped and operands corrupted after grant
    run_op(2, 6, 4, 24, 7, 4, 1, 2);

    // Round robin with all four requests held from reset
    do_reset();
    order = '{0, 1, 2, 3, 0};
    av    = '{3, 4, 5, 6};
    bv    = '{1, 2, 3, 4};
    arb_seq(4'hF, 5, order, av, bv);

    // Reset asserted mid-ADD
    @(negedge clk);
    bus.a_in[0 +: W] = 8'd7;
    bus.b_in[0 +: W] = 8'd10;
    bus.req[0]       = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt == '0 && n < 40);
    check("midadd_grant", 32'(bus.gnt), 32'(1));
    repeat (4) @(negedge clk);
    check("midadd_in_add", 32'({bus.ld_p, bus.dec}), 32'(3));
    rst = 1'b0;
    #1;
    check("midadd_reset_ctrl", 32'({bus.gnt, bus.done, bus.busy, bus.ld_a, bus.ld_b,
                                   bus.clr, bus.ld_p, bus.dec}), 32'(0));
    check("midadd_reset_data", {bus.op_a, bus.op_b, bus.result}, 32'(0));
    bus.req = '0;
    @(negedge clk);
    rst   = 1'b1;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done != '0 || bus.busy) dones++;
    end
    check("midadd_no_done", dones, 0);

    // rr_ptr back at 0: lane 0 beats lane 3, then lane 3 wins while 0 still holds req
    order = '{0, 3, 0, 0, 0};
    av    = '{2, 0, 0, 11};
    bv    = '{5, 0, 0, 2};
    arb_seq(4'b1001, 2, order, av, bv);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
